// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register with a single-shot data-cache request FSM.
// Holds the captured entry stable and back-pressures execute while an access is in flight.
module ex_mem_reg #(
  parameter int DW = 16,
  parameter int RW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ex_valid,
  input  logic [DW-1:0] ex_alu_res,
  input  logic [DW-1:0] ex_wdata,
  input  logic          ex_memRead,
  input  logic          ex_memWrite,
  input  logic          ex_regWrite,
  input  logic [RW-1:0] ex_wreg,
  input  logic [DW-1:0] ex_pc_2,
  input  logic          flush,
  input  logic          mem_done,
  input  logic          mem_stall,
  output logic          mem_valid,
  output logic [DW-1:0] ALU_res,
  output logic [DW-1:0] read2data,
  output logic          memRead,
  output logic          memWrite,
  output logic          mem_regWrite,
  output logic [RW-1:0] mem_wreg,
  output logic [DW-1:0] mem_pc_2,
  output logic          ex_stall,
  output logic          err,
  output logic [15:0]   stall_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } state_t;

  typedef struct packed {
    logic [DW-1:0] alu;
    logic [DW-1:0] wdata;
    logic          rd;
    logic          wr;
    logic          rw;
    logic [RW-1:0] wreg;
    logic [DW-1:0] pc;
  } ent_t;

  state_t      st_q;
  state_t      st_d;
  ent_t        ent_q;
  logic        vld_q;
  logic        err_q;
  logic [15:0] cnt_q;
  logic        adv;
  logic        cap_v;
  logic        cap_mem;
  logic        issue;

  assign adv     = ((st_q == IDLE) || (st_q == DONE)) && !mem_stall;
  assign cap_v   = ex_valid & ~flush;
  assign cap_mem = cap_v & (ex_memRead | ex_memWrite);
  assign issue   = (st_q == ISSUE);

  always_comb begin
    st_d = st_q;
    unique case (st_q)
      IDLE,
      DONE:    st_d = (adv && cap_mem) ? ISSUE : IDLE;
      ISSUE:   st_d = mem_done ? DONE : WAIT;
      WAIT:    if (mem_done) st_d = DONE;
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q  <= IDLE;
      ent_q <= '0;
      vld_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      st_q <= st_d;
      if (adv) begin
        ent_q <= '{
          alu:   ex_alu_res,
          wdata: ex_wdata,
          rd:    ex_memRead,
          wr:    ex_memWrite,
          rw:    ex_regWrite,
          wreg:  ex_wreg,
          pc:    ex_pc_2
        };
        vld_q <= cap_v;
        if (cap_v && ex_memRead && ex_memWrite)
          err_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      cnt_q <= '0;
    else if (ex_stall && (cnt_q != 16'hFFFF))
      cnt_q <= cnt_q + 16'd1;
  end

  // ISSUE is only entered for a valid entry; a store wins over a load.
  assign memWrite     = issue & ent_q.wr;
  assign memRead      = issue & ent_q.rd & ~ent_q.wr;
  assign mem_valid    = vld_q;
  assign mem_regWrite = vld_q & ent_q.rw;
  assign ALU_res      = ent_q.alu;
  assign read2data    = ent_q.wdata;
  assign mem_wreg     = ent_q.wreg;
  assign mem_pc_2     = ent_q.pc;
  assign ex_stall     = ~adv;
  assign err          = err_q;
  assign stall_cnt    = cnt_q;

endmodule

// File: doc/ex_mem_reg.md
Name: ex_mem_reg

Overview:
- EX/MEM pipeline register directly upstream of the memory stage.
- Captures execute-stage results and holds them stable while a data-cache access is in flight.
- Issues exactly one single-cycle read or write request per valid memory instruction and back-pressures execute until the access completes.
- Also keeps a saturating count of stall cycles for performance debug.

Parameters:
- DW, 16: data/address width.
- RW, 3: register-index width.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- ex_valid  in  1  execute stage presents an instruction.
- ex_alu_res  in  DW  ALU result / memory address.
- ex_wdata  in  DW  store data (read2data).
- ex_memRead  in  1  instruction is a load.
- ex_memWrite  in  1  instruction is a store.
- ex_regWrite  in  1  instruction writes the register file.
- ex_wreg  in  RW  destination register index.
- ex_pc_2  in  DW  PC+2 of the instruction.
- flush  in  1  squash the instruction being captured this cycle.
- mem_done  in  1  cache access complete (Done).
- mem_stall  in  1  cache busy (Stall).
- mem_valid  out  1  register holds a live instruction.
- ALU_res  out  DW  registered address/result.
- read2data  out  DW  registered store data.
- memRead  out  1  one-cycle read request pulse.
- memWrite  out  1  one-cycle write request pulse.
- mem_regWrite  out  1  registered regWrite, gated by mem_valid.
- mem_wreg  out  RW  registered destination index.
- mem_pc_2  out  DW  registered PC+2.
- ex_stall  out  1  execute must hold its outputs.
- err  out  1  sticky: read and write requested together.
- stall_cnt  out  16  saturating count of cycles with ex_stall=1.

Behaviour:
- Reset (rst=0, asynchronous): all outputs and registers 0, FSM=IDLE.
- FSM states:
  - IDLE: no access pending.
  - ISSUE: request pulse cycle.
  - WAIT: awaiting mem_done.
  - DONE: result available, one cycle.
- Advance condition: adv = (state==IDLE or state==DONE) and !mem_stall.
  - On adv, capture all ex_* fields.
  - mem_valid <= ex_valid & !flush.
  - Otherwise hold all data registers unchanged.
- IDLE/DONE with adv and captured entry valid with memRead|memWrite: next state ISSUE. Otherwise next state IDLE.
- ISSUE:
  - memRead = registered load bit, memWrite = registered store bit, for exactly one cycle.
  - Next state WAIT, or DONE if mem_done is already 1 in the same cycle.
- WAIT: stay until mem_done=1, then go to DONE. Request outputs are 0 throughout.
- DONE: one cycle; adv is allowed here.
- memRead and memWrite are 0 outside ISSUE.
- No re-request for the same entry, even if mem_stall toggles.
- ex_stall = !adv, combinational. Compute it with or without a valid entry in the register.
- Registered load and store bits both 1 at capture:
  - Treat as store: memWrite only.
  - Set err=1; err stays 1 until reset.
- flush is ignored in ISSUE and WAIT, because the in-flight store is not cancelled. In those states flush has no effect, since no capture occurs.
- Non-memory valid entries pass through in one cycle with no FSM excursion. Throughput is 1 per cycle when mem_stall=0.
- Captured entry with ex_valid=0 (bubble): memRead, memWrite, mem_regWrite all 0.
- stall_cnt increments on each ex_stall=1 cycle and saturates at 16'hFFFF without wrapping.
- Reset asserted during WAIT: FSM to IDLE immediately, mem_valid=0, no request issued after release.

Test Plan:
- ALU op, ex_valid=1, ex_alu_res=16'h1234, regWrite=1, wreg=3, mem_stall=0.
  - Next cycle: ALU_res=16'h1234, mem_valid=1, mem_regWrite=1, mem_wreg=3.
  - memRead=memWrite=0, ex_stall=0.
- Load to address 16'h0040, mem_done asserted 3 cycles after the pulse.
  - memRead=1 for exactly one cycle; ex_stall=1 through WAIT; ALU_res held at 16'h0040.
  - DONE one cycle later, then the next instruction is captured; stall_cnt=4.
- Store with ex_wdata=16'hBEEF, mem_stall pulsed high twice during WAIT.
  - Exactly one memWrite pulse; read2data=16'hBEEF held until DONE.
- flush=1 on a load capture.
  - mem_valid=0, no memRead pulse, FSM stays IDLE.
- flush=1 during WAIT of a store.
  - Store completes, single pulse, captured next entry unaffected by the stale flush.
- ex_memRead=ex_memWrite=1.
  - memWrite pulse only, memRead=0, err=1 persisting.
- Async reset (rst=0 mid-cycle) in WAIT.
  - Outputs 0 immediately; after release no request pulse, FSM IDLE, stall_cnt=0.
- Force 65540 stalled cycles.
  - stall_cnt=16'hFFFF, no wrap.
